// File: rtl/ascon_ctrl_regs.sv
// ascon_ctrl_regs: register front-end, launch/busy/done FSM and watchdog for the ASCON core (irq_o with ASCON_CTRL_IRQ_EN).
// Latency: bus response one cycle after the sampled request; start_o one cycle after the START write.
// Backpressure: none, a request may be issued every cycle and is always answered.
module ascon_ctrl_regs #(
    parameter int STATE_WORDS    = 5,
    parameter int WORD_W         = 64,
    parameter int BUS_W          = 32,
    parameter int ADDR_W         = 8,
    parameter int ROUND_W        = 4,
    parameter int DEFAULT_ROUNDS = 12,
    parameter int TIMEOUT_CYC    = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          reg_valid_i,
    input  logic                          reg_write_i,
    input  logic [ADDR_W-1:0]             reg_addr_i,
    input  logic [BUS_W-1:0]              reg_wdata_i,
    output logic                          reg_rsp_valid_o,
    output logic [BUS_W-1:0]              reg_rdata_o,
    output logic                          reg_error_o,
    output logic                          start_o,
    output logic [ROUND_W-1:0]            rounds_o,
    output logic [STATE_WORDS*WORD_W-1:0] state_o,
    input  logic                          done_i,
    input  logic                          update_state_i,
    input  logic [STATE_WORDS*WORD_W-1:0] state_i
`ifdef ASCON_CTRL_IRQ_EN
    ,
    output logic                          irq_o
`endif
);

    localparam int STATE_BITS = STATE_WORDS * WORD_W;
    localparam int NSLICE     = STATE_BITS / BUS_W;
    localparam int WD_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [STATE_BITS-1:0] state_q, state_d;
    logic [ROUND_W-1:0]    rounds_q, rounds_d;
    logic [ROUND_W-1:0]    run_rounds_q, run_rounds_d;
    logic                  irq_en_q, irq_en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  tout_q, tout_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  rsp_vld_q;
    logic [BUS_W-1:0]      rdata_q, rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  irq_q, irq_d;

    logic [ADDR_W-1:0]     k;
    logic                  aligned, busy, hit, launch;
    logic                  set_done, set_err, set_tout;
    logic [2:0]            clr;

    assign k       = reg_addr_i / ADDR_W'(BUS_W / 8);
    assign aligned = (reg_addr_i % ADDR_W'(BUS_W / 8)) == '0;
    assign busy    = (fsm_q != ST_IDLE);

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        rounds_d     = rounds_q;
        run_rounds_d = run_rounds_q;
        irq_en_d     = irq_en_q;
        wd_d         = wd_q;
        rdata_d      = '0;
        rsp_err_d    = 1'b0;
        hit          = 1'b0;
        launch       = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        set_tout     = 1'b0;
        clr          = '0;

        // Misaligned addresses are treated like unmapped ones: error, no side effects.
        if (reg_valid_i) begin
            if (!aligned) begin
                rsp_err_d = 1'b1;
            end else if (k == '0) begin
                if (!reg_write_i) begin
                    rdata_d[1]            = irq_en_q;
                    rdata_d[8 +: ROUND_W] = rounds_q;
                end else begin
`ifdef ASCON_CTRL_IRQ_EN
                    irq_en_d = reg_wdata_i[1];
`endif
                    // While busy only an attempt to launch or change ROUNDS is a violation,
                    // so software can still toggle IRQ_EN with a read-modify-write.
                    if (busy) begin
                        if (reg_wdata_i[0] || (reg_wdata_i[8 +: ROUND_W] != rounds_q)) begin
                            rsp_err_d = 1'b1;
                            set_err   = 1'b1;
                        end
                    end else begin
                        rounds_d = reg_wdata_i[8 +: ROUND_W];
                        launch   = reg_wdata_i[0];
                    end
                end
            end else if (k == ADDR_W'(1)) begin
                if (!reg_write_i) rdata_d[3:0] = {tout_q, err_q, done_q, busy};
                else              clr          = reg_wdata_i[3:1];
            end else begin
                for (int j = 0; j < NSLICE; j++) begin
                    if (k == ADDR_W'(j + 2)) begin
                        hit = 1'b1;
                        if (!reg_write_i) begin
                            rdata_d = state_q[j*BUS_W +: BUS_W];
                        end else if (busy) begin
                            rsp_err_d = 1'b1;
                            set_err   = 1'b1;
                        end else begin
                            state_d[j*BUS_W +: BUS_W] = reg_wdata_i;
                        end
                    end
                end
                if (!hit) rsp_err_d = 1'b1;
            end
        end

        if (update_state_i) state_d = state_i;

        case (fsm_q)
            ST_IDLE: begin
                if (launch) begin
                    fsm_d        = ST_LAUNCH;
                    run_rounds_d = rounds_d;
                end
            end
            ST_LAUNCH: begin
                wd_d = '0;
                if (done_i) begin
                    fsm_d    = ST_IDLE;
                    set_done = 1'b1;
                end else begin
                    fsm_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_i) begin
                    fsm_d    = ST_IDLE;
                    set_done = 1'b1;
                end else if ((TIMEOUT_CYC != 0) && ((wd_q + WD_W'(1)) == WD_W'(TIMEOUT_CYC))) begin
                    fsm_d    = ST_IDLE;
                    set_tout = 1'b1;
                    set_err  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        done_d = (done_q & ~clr[0]) | set_done;
        err_d  = (err_q  & ~clr[1]) | set_err;
        tout_d = (tout_q & ~clr[2]) | set_tout;
        irq_d  = irq_en_q & (done_q | err_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q        <= ST_IDLE;
            state_q      <= '0;
            rounds_q     <= ROUND_W'(DEFAULT_ROUNDS);
            run_rounds_q <= ROUND_W'(DEFAULT_ROUNDS);
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tout_q       <= 1'b0;
            wd_q         <= '0;
            rsp_vld_q    <= 1'b0;
            rdata_q      <= '0;
            rsp_err_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            rounds_q     <= rounds_d;
            run_rounds_q <= run_rounds_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tout_q       <= tout_d;
            wd_q         <= wd_d;
            rsp_vld_q    <= reg_valid_i;
            rdata_q      <= rdata_d;
            rsp_err_q    <= rsp_err_d;
            irq_q        <= irq_d;
        end
    end

    assign reg_rsp_valid_o = rsp_vld_q;
    assign reg_rdata_o     = rdata_q;
    assign reg_error_o     = rsp_err_q;
    assign start_o         = (fsm_q == ST_LAUNCH);
    assign rounds_o        = run_rounds_q;
    assign state_o         = state_q;
`ifdef ASCON_CTRL_IRQ_EN
    assign irq_o           = irq_q;
`endif

endmodule

// File: tb/tb_ascon_ctrl_regs.sv
// tb_ascon_ctrl_regs: directed + random traffic against a transaction-level model of the register front-end.
module tb_ascon_ctrl_regs;
    localparam int TO  = 8;
    localparam int NSL = 10;
    localparam int SB  = 320;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_valid_i, reg_write_i;
    logic [7:0]    reg_addr_i;
    logic [31:0]   reg_wdata_i;
    logic          reg_rsp_valid_o;
    logic [31:0]   reg_rdata_o;
    logic          reg_error_o;
    logic          start_o;
    logic [3:0]    rounds_o;
    logic [SB-1:0] state_o;
    logic          done_i, update_state_i;
    logic [SB-1:0] state_i;
`ifdef ASCON_CTRL_IRQ_EN
    logic          irq_o;
`endif

    always #5 clk = ~clk;

    ascon_ctrl_regs #(
        .STATE_WORDS(5), .WORD_W(64), .BUS_W(32), .ADDR_W(8),
        .ROUND_W(4), .DEFAULT_ROUNDS(12), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
        .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_rsp_valid_o(reg_rsp_valid_o), .reg_rdata_o(reg_rdata_o),
        .reg_error_o(reg_error_o), .start_o(start_o), .rounds_o(rounds_o),
        .state_o(state_o), .done_i(done_i), .update_state_i(update_state_i),
        .state_i(state_i)
`ifdef ASCON_CTRL_IRQ_EN
        , .irq_o(irq_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [SB-1:0] act, input logic [SB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: run phase 0=idle 1=launch pulse 2=waiting for core; wd counts waiting cycles.
    int            ph, wd;
    logic [SB-1:0] m_st;
    logic [3:0]    m_rnd, m_run;
    bit            m_ien, m_dn, m_er, m_to, m_irq;
    bit            e_vld, e_err;
    logic [31:0]   e_rd;

    task automatic mdl_reset();
        ph = 0; wd = 0; m_st = '0; m_rnd = 4'd12; m_run = 4'd12;
        m_ien = 0; m_dn = 0; m_er = 0; m_to = 0; m_irq = 0;
        e_vld = 0; e_err = 0; e_rd = '0;
    endtask

    task automatic mdl_step();
        bit       busy  = (ph != 0);
        bit       irq_n = m_ien && (m_dn || m_er);
        bit       sd = 0, se = 0, st = 0, go = 0;
        bit [2:0] clr = '0;
        int       k = int'(reg_addr_i) / 4;
        e_vld = reg_valid_i; e_rd = '0; e_err = 0;
        if (reg_valid_i) begin
            if (!reg_write_i) begin
                if (k == 0)                    e_rd = {20'd0, m_rnd, 6'd0, m_ien, 1'b0};
                else if (k == 1)               e_rd = {28'd0, m_to, m_er, m_dn, busy};
                else if (k >= 2 && k < 2+NSL)  e_rd = m_st[(k-2)*32 +: 32];
                else                           e_err = 1;
            end else begin
                if (k == 0) begin
`ifdef ASCON_CTRL_IRQ_EN
                    m_ien = reg_wdata_i[1];
`endif
                    if (busy) begin
                        if (reg_wdata_i[0] || reg_wdata_i[11:8] != m_rnd) begin e_err = 1; se = 1; end
                    end else begin
                        m_rnd = reg_wdata_i[11:8];
                        go    = reg_wdata_i[0];
                    end
                end else if (k == 1) begin
                    clr = reg_wdata_i[3:1];
                end else if (k >= 2 && k < 2+NSL) begin
                    if (busy) begin e_err = 1; se = 1; end
                    else if (!update_state_i) m_st[(k-2)*32 +: 32] = reg_wdata_i;
                end else begin
                    e_err = 1;
                end
            end
        end
        if (update_state_i) m_st = state_i;
        if (ph == 0) begin
            if (go) begin ph = 1; m_run = m_rnd; end
        end else if (done_i) begin
            ph = 0; sd = 1;
        end else if (ph == 1) begin
            ph = 2; wd = 0;
        end else begin
            wd++;
            if (wd == TO) begin ph = 0; st = 1; se = 1; end
        end
        m_dn  = (m_dn && !clr[0]) || sd;
        m_er  = (m_er && !clr[1]) || se;
        m_to  = (m_to && !clr[2]) || st;
        m_irq = irq_n;
    endtask

    task automatic cycle(input bit v, input bit w, input int k, input logic [31:0] wdat,
                         input bit dn, input bit up, input logic [SB-1:0] si);
        reg_valid_i = v; reg_write_i = w; reg_addr_i = 8'(k * 4); reg_wdata_i = wdat;
        done_i = dn; update_state_i = up; state_i = si;
        @(posedge clk);
        mdl_step();
        #1;
        check("rsp_vld", reg_rsp_valid_o, e_vld);
        if (v) check("rsp_err", reg_error_o, e_err);
        if (v && !w) check("rdata", reg_rdata_o, e_rd);
        check("start", start_o, (ph == 1));
        check("rounds", rounds_o, m_run);
        check("state", state_o, m_st);
`ifdef ASCON_CTRL_IRQ_EN
        check("irq", irq_o, m_irq);
`endif
    endtask

    task automatic rd(input int k);
        cycle(1, 0, k, 32'd0, 0, 0, '0);
    endtask

    task automatic wr(input int k, input logic [31:0] d);
        cycle(1, 1, k, d, 0, 0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0, 0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reg_valid_i = 0; reg_write_i = 0; reg_addr_i = '0; reg_wdata_i = '0;
        done_i = 0; update_state_i = 0; state_i = '0;
        #1;
        mdl_reset();
        check("rst_rsp", reg_rsp_valid_o, 0);
        check("rst_err", reg_error_o, 0);
        check("rst_start", start_o, 0);
        check("rst_rounds", rounds_o, 12);
        check("rst_state", state_o, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [SB-1:0] si;
    logic [31:0]   d;

    initial begin
        rst = 1'b0;
        #2;
        do_reset();
        rd(0); check("ctrl_reset", reg_rdata_o, 32'h0000_0C00);
        rd(1); check("status_reset", reg_rdata_o, 32'h0);

        for (int j = 0; j < NSL; j++) wr(2 + j, 32'h1000 + j);
        wr(0, 32'h601);
        check("launch_start", start_o, 1);
        check("launch_rounds", rounds_o, 6);
        check("word0", state_o[63:0], 64'h0000_1001_0000_1000);
        rd(1); check("busy", reg_rdata_o, 32'h1);
        check("start_pulse_end", start_o, 0);

        wr(5, 32'hDEAD_BEEF); check("prot_err", reg_error_o, 1);
        rd(5); check("prot_keep", reg_rdata_o, 32'h1003);
        si = {64'hFFFF_FFFF_FFFF_FFFF, {8{32'h5A5A_0F0F}}};
        cycle(0, 0, 0, 32'd0, 0, 1, si);
        cycle(0, 0, 0, 32'd0, 1, 0, '0);
        rd(10); check("slice8", reg_rdata_o, 32'hFFFF_FFFF);
        rd(11); check("slice9", reg_rdata_o, 32'hFFFF_FFFF);
        rd(1);  check("status_done_err", reg_rdata_o, 32'h6);

        wr(0, 32'h601);
        idle(1);
        cycle(1, 1, 1, 32'h2, 1, 0, '0);
        rd(1); check("set_beats_clr", reg_rdata_o, 32'h6);
        wr(1, 32'h6);
        rd(1); check("w1c", reg_rdata_o, 32'h0);

        wr(0, 32'h603);
        idle(TO + 4);
        rd(1); check("timeout", reg_rdata_o, 32'hC);
`ifdef ASCON_CTRL_IRQ_EN
        check("irq_timeout", irq_o, 1);
`endif

        rd(12); check("unmapped_data", reg_rdata_o, 32'h0);
        check("unmapped_err", reg_error_o, 1);
        rd(2); check("b2b_0", reg_rsp_valid_o, 1);
        rd(3); check("b2b_1", reg_rsp_valid_o, 1);
        wr(1, 32'hE);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                bit v  = ($urandom_range(0, 9) < 6);
                bit w  = $urandom_range(0, 1) == 1;
                int k  = $urandom_range(0, 13);
                bit dn = ($urandom_range(0, 11) == 0);
                bit up = ($urandom_range(0, 19) == 0);
                d = $urandom;
                if (k == 0) begin
                    d[0] = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 1) == 1) d[11:8] = m_rnd;
                end
                for (int i = 0; i < NSL; i++) si[i*32 +: 32] = $urandom;
                cycle(v, w, k, d, dn, up, si);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ascon_ctrl_regs.md
Name: ascon_ctrl_regs

Overview:
Parametrised, self-contained register front-end for the ASCON permutation core; next generation of the fixed 5x64 state register glue. Maps an N-word state onto a BUS_W-wide register bus, adds a launch/busy/done FSM, a programmable round count, sticky status with write-one-to-clear, bus write protection while the core runs, and a watchdog timeout. Sits between the SoC register bus and the ASCON datapath.

Parameters:
STATE_WORDS, 5, number of state words
WORD_W, 64, state word width; must be a multiple of BUS_W
BUS_W, 32, register bus data width
ADDR_W, 8, byte address width
ROUND_W, 4, width of round-count field
DEFAULT_ROUNDS, 12, reset value of ROUNDS
TIMEOUT_CYC, 1024, max WAIT cycles before abort; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
reg_valid_i  in  1  bus request strobe
reg_write_i  in  1  1=write, 0=read
reg_addr_i  in  ADDR_W  byte address, BUS_W/8 aligned
reg_wdata_i  in  BUS_W  write data
reg_rsp_valid_o  out  1  response strobe
reg_rdata_o  out  BUS_W  read data
reg_error_o  out  1  response error
start_o  out  1  one-cycle launch pulse to core
rounds_o  out  ROUND_W  round count for current run
state_o  out  STATE_WORDS*WORD_W  state to core; word w at [w*WORD_W +: WORD_W]
done_i  in  1  core finished pulse
update_state_i  in  1  load state_i into state registers
state_i  in  STATE_WORDS*WORD_W  processed state from core
irq_o  out  1  interrupt (only with ASCON_CTRL_IRQ_EN)

Behaviour:
- Reset: FSM IDLE; state regs 0; ROUNDS=DEFAULT_ROUNDS; IRQ_EN, DONE, ERR, TIMEOUT=0; all outputs 0 except rounds_o=DEFAULT_ROUNDS. Reset mid-run aborts silently; no done reported.
- Register map, stride BUS_W/8 bytes, index k = addr/(BUS_W/8):
  k=0 CTRL: bit0 START (write 1 = launch, reads 0), bit1 IRQ_EN rw, bits[8 +: ROUND_W] ROUNDS rw.
  k=1 STATUS: bit0 BUSY ro, bit1 DONE W1C, bit2 ERR W1C, bit3 TIMEOUT W1C.
  k=2..2+NSLICE-1 STATE slice j=k-2, NSLICE=STATE_WORDS*WORD_W/BUS_W; slice j = state bits [j*BUS_W +: BUS_W].
  Any other k: read returns 0, reg_error_o=1, no side effects.
- Bus timing: request sampled when reg_valid_i=1; reg_rsp_valid_o/rdata/error asserted exactly one cycle later, for one cycle. Back-to-back requests allowed every cycle. Writes take effect at the sampling edge; a read returns the value before any same-cycle write.
- FSM: IDLE -> LAUNCH on START write in IDLE. LAUNCH: start_o=1 for one cycle, BUSY=1, ROUNDS latched to rounds_o -> WAIT. WAIT -> IDLE on done_i: DONE set. done_i during LAUNCH is accepted identically. done_i in IDLE ignored.
- Watchdog: counter cleared in LAUNCH, increments each WAIT cycle; on reaching TIMEOUT_CYC -> IDLE with TIMEOUT and ERR set. done_i in that same cycle wins: DONE set, no TIMEOUT.
- Protection while BUSY: writes to STATE slices, CTRL.ROUNDS and START are dropped, ERR set, reg_error_o=1. STATUS W1C and IRQ_EN writes still apply. Reads always allowed.
- update_state_i loads state_i into all words in any FSM state. It beats a same-cycle bus state write; that write is lost, with no error.
- Sticky set beats same-cycle W1C clear.
- ROUNDS=0 is legal and is passed through unchanged.

Optional Feature:
ASCON_CTRL_IRQ_EN. Defined: irq_o port present; irq_o = registered (IRQ_EN & (DONE | ERR)), one cycle after the flag sets. Undefined: irq_o port absent; IRQ_EN reads 0 and writes to it are ignored.

Test Plan:
- Reset, read k=0 and k=1 -> 0x00000C00 and 0x0; state_o=0; start_o=0.
- Write slices 0..9 with 0x1000+j, write CTRL=0x601 -> start_o one pulse, rounds_o=6, BUSY=1; state_o word 0 = 0x0000100100001000.
- In WAIT, write slice 3 -> reg_error_o=1, slice unchanged, ERR=1; update_state_i with state_i word 4 = all 1s then done_i -> slices 8,9 read 0xFFFFFFFF, STATUS=0x6.
- Write STATUS=0x2 in the same cycle done_i sets DONE -> DONE remains 1; a later write of 0x6 clears DONE and ERR.
- TIMEOUT_CYC=8, launch without done_i -> IDLE after 8 WAIT cycles, STATUS=0xC; with IRQ_EN set and macro defined -> irq_o=1.
- Read k=12 with NSLICE=10 -> rdata 0, reg_error_o=1; back-to-back reads of k=2,3 -> responses on consecutive cycles.
